// File: rtl/button_pkg.sv
// Shared constants for the push-button front end.
// Channel indices, channel FSM encoding and default timing values.
package button_pkg;

  localparam int CH_DROP  = 0;
  localparam int CH_RIGHT = 1;
  localparam int CH_LEFT  = 2;
  localparam int NUM_CH   = 3;

  localparam int unsigned DEF_CNT_BITS = 16;

  localparam logic [15:0] DEF_DEBOUNCE      = 16'd50000;
  localparam logic [15:0] DEF_REPEAT_DELAY  = 16'd40000;
  localparam logic [15:0] DEF_REPEAT_PERIOD = 16'd20000;

  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop sync, debounce, press FSM, optional repeat.
// Auto-repeat is compiled in only with BUTTON_AUTOREPEAT_EN defined.
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned CNT_BITS = DEF_CNT_BITS,
  parameter logic [CNT_BITS-1:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE
`ifdef BUTTON_AUTOREPEAT_EN
  ,
  parameter bit REPEAT_EN = 1'b0,
  parameter logic [CNT_BITS-1:0] REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter logic [CNT_BITS-1:0] REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic req
);

  localparam logic [CNT_BITS-1:0] ONE  = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] LAST = DEBOUNCE_CYCLES - ONE;

  logic                sync1;
  logic                sync2;
  logic                stable;
  logic [CNT_BITS-1:0] cnt;
  ch_state_e           state;
  logic                differ;
  logic                settle;

  assign differ = sync2 != stable;
  assign settle = differ && (cnt == LAST);

`ifdef BUTTON_AUTOREPEAT_EN
  logic [CNT_BITS-1:0] rcnt;
  logic                first;
  logic [CNT_BITS-1:0] rlast;

  assign rlast = first ? REPEAT_DELAY - ONE
                       : REPEAT_PERIOD - ONE;
`endif

  // Bring the raw asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has held for the full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      if (settle) begin
        stable <= sync2;
      end
      if (!differ || settle) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

  // Press FSM: one req per debounced press, plus repeats when held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RELEASED;
      req   <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      rcnt  <= '0;
      first <= 1'b1;
`endif
    end else begin
      req <= 1'b0;
      unique case (state)
        ST_RELEASED: begin
          if (settle && !sync2) begin
            state <= ST_PRESSED;
            req   <= 1'b1;
          end
        end
        ST_PRESSED: begin
          if (settle && sync2) begin
            state <= ST_RELEASED;
`ifdef BUTTON_AUTOREPEAT_EN
            rcnt  <= '0;
            first <= 1'b1;
          end else if (REPEAT_EN) begin
            if (rcnt == rlast) begin
              req   <= 1'b1;
              rcnt  <= '0;
              first <= 1'b0;
            end else begin
              rcnt <= rcnt + ONE;
            end
`endif
          end
        end
        default: state <= ST_RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Three debounced buttons -> one-cycle active-low commands, one per cycle.
// Optional auto-repeat on right/left: define BUTTON_AUTOREPEAT_EN.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned CNT_BITS = DEF_CNT_BITS,
  parameter logic [CNT_BITS-1:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter logic [CNT_BITS-1:0] REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter logic [CNT_BITS-1:0] REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_right_n,
  input  logic btn_left_n,
  input  logic btn_drop_n,
  output logic move_right,
  output logic move_left,
  output logic drop_piece
);

  logic [NUM_CH-1:0] btn_n;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] avail;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] cmd_n;

  if (DEBOUNCE_CYCLES == '0) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  if (REPEAT_DELAY == '0 || REPEAT_PERIOD == '0) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be nonzero");
  end

  assign btn_n[CH_DROP]  = btn_drop_n;
  assign btn_n[CH_RIGHT] = btn_right_n;
  assign btn_n[CH_LEFT]  = btn_left_n;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    debounce_channel #(
      .CNT_BITS        (CNT_BITS),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_AUTOREPEAT_EN
      ,
      .REPEAT_EN       (ch != CH_DROP),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (btn_n[ch]),
      .req   (req[ch])
    );
  end

  // A fresh req can be granted in the same cycle it arrives.
  assign avail = pend | req;

  // Fixed priority: drop, then right, then left.
  always_comb begin
    grant = '0;
    unique case (1'b1)
      avail[CH_DROP]: grant[CH_DROP] = 1'b1;
      avail[CH_RIGHT] && !avail[CH_DROP]:
        grant[CH_RIGHT] = 1'b1;
      avail[CH_LEFT] && !avail[CH_DROP]
        && !avail[CH_RIGHT]:
        grant[CH_LEFT] = 1'b1;
      default: grant = '0;
    endcase
  end

  // Sticky pending bits and registered active-low command pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= '0;
      cmd_n <= '1;
    end else begin
      pend  <= avail & ~grant;
      cmd_n <= ~grant;
    end
  end

  assign drop_piece = cmd_n[CH_DROP];
  assign move_right = cmd_n[CH_RIGHT];
  assign move_left  = cmd_n[CH_LEFT];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with a 4-cycle debounce window.
// Repeat pulses are expected only when BUTTON_AUTOREPEAT_EN is defined.
`timescale 1ns/1ps
module tb_button_conditioner;
  import button_pkg::*;

  localparam int D   = 4;
  localparam int LAT = D + 2;

  typedef struct {
    int cyc;
    int ch;
  } exp_t;

  typedef struct {
    logic [2:0] mask;
    int         hold;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn_n = 3'b111;
  logic       move_right;
  logic       move_left;
  logic       drop_piece;
  logic [2:0] outs;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  exp_t got;

  always #5 clk = ~clk;

  assign outs[CH_DROP]  = drop_piece;
  assign outs[CH_RIGHT] = move_right;
  assign outs[CH_LEFT]  = move_left;

  button_conditioner #(
    .CNT_BITS        (16),
    .DEBOUNCE_CYCLES (16'd4),
    .REPEAT_DELAY    (16'd10),
    .REPEAT_PERIOD   (16'd5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_right_n (btn_n[CH_RIGHT]),
    .btn_left_n  (btn_n[CH_LEFT]),
    .btn_drop_n  (btn_n[CH_DROP]),
    .move_right  (move_right),
    .move_left   (move_left),
    .drop_piece  (drop_piece)
  );

  task automatic push_exp(input int c, input int ch);
    exp_t e;
    e.cyc = c;
    e.ch  = ch;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every low output must match the oldest expected pulse.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int ch = 0; ch < 3; ch++) begin
        if (!outs[ch]) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected ch=%0d cyc=%0d: %s",
                     ch, cyc, "actual low, required high");
          end else begin
            got = sb.pop_front();
            if (got.ch != ch || got.cyc != cyc) begin
              bad++;
              $display("FAIL pulse actual ch=%0d cyc=%0d %s%0d cyc=%0d",
                       ch, cyc, "required ch=", got.ch, got.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    vec_t vt[6];
    int   k;
    int   rank;

    vt[0] = '{mask: 3'b010, hold: 10};
    vt[1] = '{mask: 3'b100, hold: 10};
    vt[2] = '{mask: 3'b001, hold: 10};
    vt[3] = '{mask: 3'b111, hold: 12};
    vt[4] = '{mask: 3'b110, hold: 12};
    vt[5] = '{mask: 3'b101, hold: 12};

    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (outs !== 3'b111) begin
        bad++;
        $display("FAIL reset_idle actual=%b required=111", outs);
      end
    end

    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      k = cyc + 1;
      btn_n = ~vt[i].mask;
      rank = 0;
      for (int ch = 0; ch < 3; ch++) begin
        if (vt[i].mask[ch]) begin
          push_exp(k + LAT + rank, ch);
          rank++;
        end
      end
      tick(vt[i].hold);
      btn_n = 3'b111;
      tick(20);
    end

    for (int i = 0; i < 10; i++) begin
      btn_n[CH_RIGHT] = (i % 2 == 1);
      tick(2);
    end
    k = cyc + 1;
    btn_n[CH_RIGHT] = 1'b0;
    push_exp(k + LAT, CH_RIGHT);
    tick(15);
    btn_n = 3'b111;
    tick(20);

    k = cyc + 1;
    btn_n[CH_LEFT] = 1'b0;
    push_exp(k + LAT, CH_LEFT);
    repeat (LAT + 1) @(posedge clk);
    #2;
    total++;
    if (move_left !== 1'b0) begin
      bad++;
      $display("FAIL held_pulse actual=%b required=0", move_left);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (outs !== 3'b111) begin
      bad++;
      $display("FAIL async_reset actual=%b required=111", outs);
    end
    @(negedge clk);
    tick(2);
    rst_n = 1'b1;
    k = cyc + 1;
    push_exp(k + LAT, CH_LEFT);
    tick(15);
    btn_n = 3'b111;
    tick(20);

    k = cyc + 1;
    btn_n[CH_RIGHT] = 1'b0;
    push_exp(k + LAT, CH_RIGHT);
`ifdef BUTTON_AUTOREPEAT_EN
    push_exp(k + LAT + 10, CH_RIGHT);
    push_exp(k + LAT + 15, CH_RIGHT);
    push_exp(k + LAT + 20, CH_RIGHT);
    push_exp(k + LAT + 25, CH_RIGHT);
`endif
    tick(30);
    btn_n = 3'b111;
    tick(20);

    k = cyc + 1;
    btn_n[CH_DROP] = 1'b0;
    push_exp(k + LAT, CH_DROP);
    tick(30);
    btn_n = 3'b111;
    tick(20);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_pulses actual=%0d required=0",
               sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
